codificador_entrada: RTL and testbench
======================================

// Module: codificador_entrada
// PURPOSE
//  Operand entry encoder: assembles decimal digits, entered one at a time, into two
//  7-bit binary operands a and b (0..99 each), which are the values the 7-segment
//  display path decodes back into digits. Sits between the keypad/switch digit
//  source and the FSM datapath. Entry order: tens of a, units of a, tens of b, units of b.
// PARAMETERS
//  TIMEOUT  50_000_000  idle cycles allowed between digits of a started entry; 0 = no timeout
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  digit        in   4  BCD digit offered
//  digit_valid  in   1  digit is offered this cycle (one cycle per digit)
//  cancel       in   1  abandon the entry in progress
//  a            out  7  last completed operand a (binary, 0..99)
//  b            out  7  last completed operand b (binary, 0..99)
//  out_valid    out  1  one-cycle pulse: a/b were just updated
//  busy         out  1  at least one digit of the current sequence is accepted
//  entry_pos    out  2  next expected digit: 0 dez_a, 1 uni_a, 2 dez_b, 3 uni_b
//  err          out  1  one-cycle pulse: offered digit was > 9 and was rejected
//  timeout      out  1  one-cycle pulse: entry aborted by the idle timer
// BEHAVIOUR
//  - Reset: a=0, b=0, out_valid=0, err=0, timeout=0, busy=0, entry_pos=0,
//    state S_DEZ_A, timer=0, partial registers=0.
//  - FSM states S_DEZ_A -> S_UNI_A -> S_DEZ_B -> S_UNI_B -> S_DEZ_A. entry_pos is the
//    state encoding 0..3. busy = (state != S_DEZ_A).
//  - Per-cycle priority: reset > cancel > digit_valid > timer expiry.
//  - Accept: digit_valid=1 and digit<=9 advances one state and stores the digit.
//    Tens digits are stored as d*10 computed as (d<<3)+(d<<1). Units are added to
//    the stored tens. Max 9*10+9 = 99, fits 7 bits, no saturation needed.
//  - Reject: digit_valid=1 and digit>9 -> err=1 on the next cycle. State, partials
//    and timer are unchanged.
//  - Completion: accepting a digit in S_UNI_B loads a and b on the same edge and
//    raises out_valid for exactly one cycle (latency 1 clock from digit_valid).
//    State returns to S_DEZ_A. a and b hold until the next completion and never
//    show partial values.
//  - cancel=1: state -> S_DEZ_A, partials cleared, timer cleared. a, b and
//    out_valid are unaffected, and no err or timeout pulse is produced. Any
//    digit_valid in the same cycle is ignored.
//  - Timer: clear while state is S_DEZ_A and on every accepted digit. Otherwise it
//    increments each cycle. When busy, TIMEOUT!=0, timer==TIMEOUT-1, and neither
//    cancel nor digit_valid is present: state -> S_DEZ_A, partials cleared, and
//    timeout=1 on the next cycle. Width is $clog2(TIMEOUT+1). With TIMEOUT=0 the
//    timer is held at 0.
//  - An invalid digit does not restart the timer.
//  - err, timeout and out_valid are mutually exclusive in any cycle.
//  - Reset mid-entry discards partials and also clears a and b.
// TESTING
//  1. Reset, then offer 4,2,0,7 on consecutive cycles -> a=42, b=7, out_valid one
//     cycle after the 7, entry_pos back to 0.
//  2. Offer 9,9,9,9 -> a=99, b=99. Then offer 0,0,0,0 -> a=0, b=0, two separate
//     out_valid pulses.
//  3. Offer 1, then 12 (0xC), then 5 -> err pulses once. Sequence continues with
//     entry_pos=2, and a=15 after completion with b=... digits 3,6 -> b=36.
//  4. Complete 1,2,3,4, then offer 5,6 and assert cancel -> entry_pos=0, busy=0,
//     a=12, b=34 hold, no out_valid.
//  5. TIMEOUT=8: offer 3, then idle -> timeout pulse 8 cycles after the accept
//     cycle, entry_pos=0. Then 1,1,2,2 -> a=11, b=22.
//  6. Assert reset after 2 digits -> all outputs at reset values on the next cycle.
//     Cancel together with digit_valid -> digit ignored.

Source files
------------

// File: rtl/codificador_entrada.sv
// rtl/codificador_entrada.sv - assembles four BCD digits into two binary operands a and b
module codificador_entrada #(
    parameter int TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       cancel,
    output logic [6:0] a,
    output logic [6:0] b,
    output logic       out_valid,
    output logic       busy,
    output logic [1:0] entry_pos,
    output logic       err,
    output logic       timeout
);

    // A zero TIMEOUT would give a zero-width timer; keep one bit and hold it at 0.
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        S_DEZ_A = 2'd0,
        S_UNI_A = 2'd1,
        S_DEZ_B = 2'd2,
        S_UNI_B = 2'd3
    } state_t;

    state_t        state_q;
    logic [6:0]    part_a_q;
    logic [6:0]    tens_b_q;
    logic [6:0]    a_q;
    logic [6:0]    b_q;
    logic          out_valid_q;
    logic          err_q;
    logic          timeout_q;
    logic [TW-1:0] timer_q;

    logic [6:0]    digit_ext;
    logic [6:0]    tens_d;
    logic          digit_ok;
    logic          expire;
    logic [TW-1:0] timer_d;

    // Digit arithmetic and idle-timer next value; tens use shift-add instead of a multiplier.
    always_comb begin
        digit_ext = {3'b000, digit};
        tens_d    = (digit_ext << 3) + (digit_ext << 1);
        digit_ok  = (digit <= 4'd9);
        expire    = (TIMEOUT != 0) && (state_q != S_DEZ_A) && (timer_q == TW'(TLAST));
        if ((state_q == S_DEZ_A) || (TIMEOUT == 0)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Entry FSM: priority reset > cancel > digit_valid > timer expiry; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_DEZ_A;
            part_a_q    <= '0;
            tens_b_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            if (cancel) begin
                state_q  <= S_DEZ_A;
                part_a_q <= '0;
                tens_b_q <= '0;
                timer_q  <= '0;
            end else if (digit_valid) begin
                if (digit_ok) begin
                    timer_q <= '0;
                    case (state_q)
                        S_DEZ_A: begin
                            part_a_q <= tens_d;
                            state_q  <= S_UNI_A;
                        end
                        S_UNI_A: begin
                            part_a_q <= part_a_q + digit_ext;
                            state_q  <= S_DEZ_B;
                        end
                        S_DEZ_B: begin
                            tens_b_q <= tens_d;
                            state_q  <= S_UNI_B;
                        end
                        default: begin
                            a_q         <= part_a_q;
                            b_q         <= tens_b_q + digit_ext;
                            out_valid_q <= 1'b1;
                            part_a_q    <= '0;
                            tens_b_q    <= '0;
                            state_q     <= S_DEZ_A;
                        end
                    endcase
                end else begin
                    // Rejected digit leaves state, partials and timer untouched.
                    err_q <= 1'b1;
                end
            end else if (expire) begin
                state_q   <= S_DEZ_A;
                part_a_q  <= '0;
                tens_b_q  <= '0;
                timer_q   <= '0;
                timeout_q <= 1'b1;
            end else begin
                timer_q <= timer_d;
            end
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign timeout   = timeout_q;
    assign entry_pos = state_q;
    assign busy      = (state_q != S_DEZ_A);

endmodule

// File: tb/tb_codificador_entrada.sv
// tb/tb_codificador_entrada.sv - directed vector bench for codificador_entrada
module tb_codificador_entrada;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       digit_valid = 1'b0;
    logic       cancel = 1'b0;
    logic [6:0] a;
    logic [6:0] b;
    logic       out_valid;
    logic       busy;
    logic [1:0] entry_pos;
    logic       err;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    codificador_entrada #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit       (digit),
        .digit_valid (digit_valid),
        .cancel      (cancel),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .busy        (busy),
        .entry_pos   (entry_pos),
        .err         (err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [3:0] d;
        logic       can;
        logic [6:0] ea;
        logic [6:0] eb;
        logic       eov;
        logic       ebusy;
        logic [1:0] epos;
        logic       eerr;
        logic       eto;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic dv, input logic [3:0] d, input logic can,
                       input logic [6:0] ea, input logic [6:0] eb, input logic eov,
                       input logic ebusy, input logic [1:0] epos, input logic eerr,
                       input logic eto);
        vec_t v;
        v.rst = rst; v.dv = dv; v.d = d; v.can = can;
        v.ea = ea; v.eb = eb; v.eov = eov; v.ebusy = ebusy;
        v.epos = epos; v.eerr = eerr; v.eto = eto;
        vecs.push_back(v);
    endtask

    // Drive inputs at the falling edge, let one rising edge consume them, return at the next falling edge.
    task automatic cycle(input logic rst, input logic dv, input logic [3:0] d, input logic can);
        reset = rst; digit_valid = dv; digit = d; cancel = can;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; digit_valid = 1'b0; digit = 4'd0; cancel = 1'b0;
    endtask

    task automatic chk(input string name, input logic [6:0] ea, input logic [6:0] eb,
                       input logic eov, input logic ebusy, input logic [1:0] epos,
                       input logic eerr, input logic eto);
        checks++;
        if ({a, b, out_valid, busy, entry_pos, err, timeout} !==
            {ea, eb, eov, ebusy, epos, eerr, eto}) begin
            errors++;
            $display("FAIL %s: got a=%0d b=%0d ov=%0b busy=%0b pos=%0d err=%0b to=%0b, expected a=%0d b=%0d ov=%0b busy=%0b pos=%0d err=%0b to=%0b",
                     name, a, b, out_valid, busy, entry_pos, err, timeout,
                     ea, eb, eov, ebusy, epos, eerr, eto);
        end
    endtask

    initial begin
        //   rst dv d  can   a   b ov bsy pos err to
        add(1, 0, 0,  0,   0,  0, 0, 0, 0, 0, 0);  // reset state
        add(0, 1, 4,  0,   0,  0, 0, 1, 1, 0, 0);  // 4,2,0,7
        add(0, 1, 2,  0,   0,  0, 0, 1, 2, 0, 0);
        add(0, 1, 0,  0,   0,  0, 0, 1, 3, 0, 0);
        add(0, 1, 7,  0,  42,  7, 1, 0, 0, 0, 0);
        add(0, 0, 0,  0,  42,  7, 0, 0, 0, 0, 0);
        add(0, 1, 9,  0,  42,  7, 0, 1, 1, 0, 0);  // 9,9,9,9
        add(0, 1, 9,  0,  42,  7, 0, 1, 2, 0, 0);
        add(0, 1, 9,  0,  42,  7, 0, 1, 3, 0, 0);
        add(0, 1, 9,  0,  99, 99, 1, 0, 0, 0, 0);
        add(0, 1, 0,  0,  99, 99, 0, 1, 1, 0, 0);  // 0,0,0,0 back to back
        add(0, 1, 0,  0,  99, 99, 0, 1, 2, 0, 0);
        add(0, 1, 0,  0,  99, 99, 0, 1, 3, 0, 0);
        add(0, 1, 0,  0,   0,  0, 1, 0, 0, 0, 0);
        add(0, 0, 0,  0,   0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 1,  0,   0,  0, 0, 1, 1, 0, 0);  // 1, 0xC rejected, 5, 3, 6
        add(0, 1, 12, 0,   0,  0, 0, 1, 1, 1, 0);
        add(0, 1, 5,  0,   0,  0, 0, 1, 2, 0, 0);
        add(0, 1, 3,  0,   0,  0, 0, 1, 3, 0, 0);
        add(0, 1, 6,  0,  15, 36, 1, 0, 0, 0, 0);
        add(0, 1, 1,  0,  15, 36, 0, 1, 1, 0, 0);  // 1,2,3,4
        add(0, 1, 2,  0,  15, 36, 0, 1, 2, 0, 0);
        add(0, 1, 3,  0,  15, 36, 0, 1, 3, 0, 0);
        add(0, 1, 4,  0,  12, 34, 1, 0, 0, 0, 0);
        add(0, 1, 5,  0,  12, 34, 0, 1, 1, 0, 0);  // 5,6 then cancel
        add(0, 1, 6,  0,  12, 34, 0, 1, 2, 0, 0);
        add(0, 0, 0,  1,  12, 34, 0, 0, 0, 0, 0);
        add(0, 1, 7,  1,  12, 34, 0, 0, 0, 0, 0);  // cancel+digit while idle
        add(0, 1, 5,  0,  12, 34, 0, 1, 1, 0, 0);
        add(0, 1, 6,  1,  12, 34, 0, 0, 0, 0, 0);  // cancel+digit mid-entry
        add(0, 1, 8,  0,  12, 34, 0, 1, 1, 0, 0);  // restart: 8 is tens of a
        add(0, 1, 15, 0,  12, 34, 0, 1, 1, 1, 0);
        add(0, 1, 2,  1,  12, 34, 0, 0, 0, 0, 0);
        add(0, 1, 10, 0,  12, 34, 0, 0, 0, 1, 0);  // reject at position 0
        add(0, 1, 1,  0,  12, 34, 0, 1, 1, 0, 0);  // reset after two digits
        add(0, 1, 2,  0,  12, 34, 0, 1, 2, 0, 0);
        add(1, 1, 3,  0,   0,  0, 0, 0, 0, 0, 0);
        add(0, 0, 0,  0,   0,  0, 0, 0, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].dv, vecs[i].d, vecs[i].can);
            chk($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eov,
                vecs[i].ebusy, vecs[i].epos, vecs[i].eerr, vecs[i].eto);
        end

        // Idle timeout: the pulse appears on the eighth edge after the accepting edge.
        cycle(0, 1, 3, 0);
        chk("to_accept", 0, 0, 0, 1, 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 0, 0, 0);
            if (i == 8) chk("to_expire", 0, 0, 0, 0, 0, 0, 1);
            else        chk($sformatf("to_wait%0d", i), 0, 0, 0, 1, 1, 0, 0);
        end
        cycle(0, 0, 0, 0);
        chk("to_after", 0, 0, 0, 0, 0, 0, 0);

        // Accepted digits restart the timer: gaps of 6 idle cycles never expire.
        cycle(0, 1, 1, 0);
        chk("slow_d1", 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0);
            chk("slow_gap1", 0, 0, 0, 1, 1, 0, 0);
        end
        cycle(0, 1, 1, 0);
        chk("slow_d2", 0, 0, 0, 1, 2, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0);
            chk("slow_gap2", 0, 0, 0, 1, 2, 0, 0);
        end
        cycle(0, 1, 2, 0);
        chk("slow_d3", 0, 0, 0, 1, 3, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0);
            chk("slow_gap3", 0, 0, 0, 1, 3, 0, 0);
        end
        cycle(0, 1, 2, 0);
        chk("slow_done", 11, 22, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("slow_hold", 11, 22, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
